// File: rtl/tnet_rx_decoder.sv
// rtl/tnet_rx_decoder.sv - Aurora RX frame decoder: 3-beat command frames to a held command register
// Checks the frame checksum and destination, and keeps saturating per-outcome statistics.
module tnet_rx_decoder #(
    parameter int          CNT_W    = 16,
    parameter logic [9:0]  BCAST_ID = 10'h3FF
) (
    input  logic              user_clk_i,
    input  logic              user_rst_i,
    input  logic              channel_up_i,
    input  logic              s_axi_rx_tvalid_i,
    input  logic [63:0]       s_axi_rx_tdata_i,
    input  logic              s_axi_rx_tlast_i,
    input  logic [9:0]        local_id_i,
    output logic              cmd_valid_o,
    input  logic              cmd_ready_i,
    output logic [4:0]        cmd_op_o,
    output logic [9:0]        cmd_src_o,
    output logic [31:0]       cmd_dt1_o,
    output logic [31:0]       cmd_dt2_o,
    output logic [31:0]       cmd_dt3_o,
    output logic [CNT_W-1:0]  frm_ok_cnt_o,
    output logic [CNT_W-1:0]  err_len_cnt_o,
    output logic [CNT_W-1:0]  err_chk_cnt_o,
    output logic [CNT_W-1:0]  err_ovf_cnt_o
);

    typedef enum logic [1:0] {IDLE, B1, B2, DROP} state_t;

    state_t      state, state_nxt;
    logic        take0, take1, eval, len_err;
    logic [4:0]  op_q;
    logic [9:0]  dst_q, src_q;
    logic [31:0] dt1_q, dt2_q, xor_acc;
    logic [31:0] chk_calc;
    logic        chk_ok, dst_ok, out_free, deliver, ovf, bad_chk;

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) state <= IDLE;
        else            state <= state_nxt;
    end

    // Channel loss overrides everything: beats on a down channel are never consumed.
    always_comb begin
        state_nxt = state;
        take0     = 1'b0;
        take1     = 1'b0;
        eval      = 1'b0;
        len_err   = 1'b0;
        if (!channel_up_i) begin
            state_nxt = IDLE;
        end else if (s_axi_rx_tvalid_i) begin
            case (state)
                IDLE: begin
                    if (s_axi_rx_tlast_i) begin
                        len_err = 1'b1;
                    end else begin
                        take0     = 1'b1;
                        state_nxt = B1;
                    end
                end
                B1: begin
                    if (s_axi_rx_tlast_i) begin
                        len_err   = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        take1     = 1'b1;
                        state_nxt = B2;
                    end
                end
                B2: begin
                    if (s_axi_rx_tlast_i) begin
                        eval      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        len_err   = 1'b1;
                        state_nxt = DROP;
                    end
                end
                DROP: begin
                    if (s_axi_rx_tlast_i) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign chk_calc = xor_acc ^ s_axi_rx_tdata_i[63:32];
    assign chk_ok   = (chk_calc == s_axi_rx_tdata_i[31:0]);
    assign dst_ok   = (dst_q == local_id_i) || (dst_q == BCAST_ID);
    assign out_free = !cmd_valid_o || cmd_ready_i;
    assign deliver  = eval && chk_ok && dst_ok && out_free;
    assign ovf      = eval && chk_ok && dst_ok && !out_free;
    assign bad_chk  = eval && !chk_ok;

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            op_q    <= '0;
            dst_q   <= '0;
            src_q   <= '0;
            dt1_q   <= '0;
            dt2_q   <= '0;
            xor_acc <= '0;
        end else if (take0) begin
            op_q    <= s_axi_rx_tdata_i[63:59];
            dst_q   <= s_axi_rx_tdata_i[58:49];
            src_q   <= s_axi_rx_tdata_i[48:39];
            xor_acc <= s_axi_rx_tdata_i[63:32] ^ s_axi_rx_tdata_i[31:0];
        end else if (take1) begin
            dt1_q   <= s_axi_rx_tdata_i[63:32];
            dt2_q   <= s_axi_rx_tdata_i[31:0];
            xor_acc <= xor_acc ^ s_axi_rx_tdata_i[63:32] ^ s_axi_rx_tdata_i[31:0];
        end
    end

    // Output register reloads in the same cycle it is consumed, so back-to-back frames never stall.
    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            cmd_valid_o <= 1'b0;
            cmd_op_o    <= '0;
            cmd_src_o   <= '0;
            cmd_dt1_o   <= '0;
            cmd_dt2_o   <= '0;
            cmd_dt3_o   <= '0;
        end else if (deliver) begin
            cmd_valid_o <= 1'b1;
            cmd_op_o    <= op_q;
            cmd_src_o   <= src_q;
            cmd_dt1_o   <= dt1_q;
            cmd_dt2_o   <= dt2_q;
            cmd_dt3_o   <= s_axi_rx_tdata_i[63:32];
        end else if (cmd_valid_o && cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
        end
    end

    always_ff @(posedge user_clk_i or posedge user_rst_i) begin
        if (user_rst_i) begin
            frm_ok_cnt_o  <= '0;
            err_len_cnt_o <= '0;
            err_chk_cnt_o <= '0;
            err_ovf_cnt_o <= '0;
        end else begin
            if (deliver && !(&frm_ok_cnt_o))  frm_ok_cnt_o  <= frm_ok_cnt_o + CNT_W'(1);
            if (len_err && !(&err_len_cnt_o)) err_len_cnt_o <= err_len_cnt_o + CNT_W'(1);
            if (bad_chk && !(&err_chk_cnt_o)) err_chk_cnt_o <= err_chk_cnt_o + CNT_W'(1);
            if (ovf && !(&err_ovf_cnt_o))     err_ovf_cnt_o <= err_ovf_cnt_o + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_tnet_rx_decoder.sv
// tb/tb_tnet_rx_decoder.sv - scoreboard bench for tnet_rx_decoder with a frame-level reference model
// A second instance built with CNT_W=4 shares the stimulus to exercise counter saturation.
module tb_tnet_rx_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        chan_up = 1'b0;
    logic        tvalid = 1'b0;
    logic        tlast = 1'b0;
    logic [63:0] tdata = '0;
    logic [9:0]  local_id = 10'h012;
    logic        ready = 1'b1;

    logic        cmd_valid, cmd_valid4;
    logic [4:0]  cmd_op, cmd_op4;
    logic [9:0]  cmd_src, cmd_src4;
    logic [31:0] dt1, dt2, dt3, dt1_4, dt2_4, dt3_4;
    logic [15:0] ok_cnt, len_cnt, chk_cnt, ovf_cnt;
    logic [3:0]  ok4, len4, chk4, ovf4;

    tnet_rx_decoder dut (
        .user_clk_i(clk), .user_rst_i(rst), .channel_up_i(chan_up),
        .s_axi_rx_tvalid_i(tvalid), .s_axi_rx_tdata_i(tdata), .s_axi_rx_tlast_i(tlast),
        .local_id_i(local_id), .cmd_valid_o(cmd_valid), .cmd_ready_i(ready),
        .cmd_op_o(cmd_op), .cmd_src_o(cmd_src), .cmd_dt1_o(dt1), .cmd_dt2_o(dt2), .cmd_dt3_o(dt3),
        .frm_ok_cnt_o(ok_cnt), .err_len_cnt_o(len_cnt), .err_chk_cnt_o(chk_cnt), .err_ovf_cnt_o(ovf_cnt)
    );

    tnet_rx_decoder #(.CNT_W(4)) dut4 (
        .user_clk_i(clk), .user_rst_i(rst), .channel_up_i(chan_up),
        .s_axi_rx_tvalid_i(tvalid), .s_axi_rx_tdata_i(tdata), .s_axi_rx_tlast_i(tlast),
        .local_id_i(local_id), .cmd_valid_o(cmd_valid4), .cmd_ready_i(ready),
        .cmd_op_o(cmd_op4), .cmd_src_o(cmd_src4), .cmd_dt1_o(dt1_4), .cmd_dt2_o(dt2_4), .cmd_dt3_o(dt3_4),
        .frm_ok_cnt_o(ok4), .err_len_cnt_o(len4), .err_chk_cnt_o(chk4), .err_ovf_cnt_o(ovf4)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  op;
        logic [9:0]  src;
        logic [31:0] d1, d2, d3;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int   m_ok = 0, m_len = 0, m_chk = 0, m_ovf = 0;
    logic ovf_mode = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] s4(input int v);
        return (v > 15) ? 128'd15 : 128'(v);
    endfunction

    task automatic check_counters(input string tag);
        chk({tag, "_frm_ok"}, ok_cnt, m_ok);
        chk({tag, "_err_len"}, len_cnt, m_len);
        chk({tag, "_err_chk"}, chk_cnt, m_chk);
        chk({tag, "_err_ovf"}, ovf_cnt, m_ovf);
        chk({tag, "_frm_ok4"}, ok4, s4(m_ok));
        chk({tag, "_err_len4"}, len4, s4(m_len));
        chk({tag, "_err_chk4"}, chk4, s4(m_chk));
        chk({tag, "_err_ovf4"}, ovf4, s4(m_ovf));
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic beat(input logic [63:0] d, input logic last);
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom(), $urandom()};
    endfunction

    // Three correctly-formed beats; the model decides the outcome from the frame's contents.
    task automatic send_frame(input logic [4:0] op, input logic [9:0] dst, input logic [9:0] src,
                              input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] d3,
                              input logic flip, input int gap);
        logic [63:0] b0, b1, b2;
        logic [63:0] junk;
        logic [31:0] c;
        exp_t e;
        junk = rnd64();
        b0 = {op, dst, src, junk[38:0]};
        b1 = {d1, d2};
        c  = b0[63:32] ^ b0[31:0] ^ d1 ^ d2 ^ d3;
        if (flip) c = c ^ 32'h1;
        b2 = {d3, c};
        beat(b0, 1'b0);
        idle($urandom_range(0, gap));
        beat(b1, 1'b0);
        idle($urandom_range(0, gap));
        if (flip) begin
            m_chk++;
        end else if (dst == local_id || dst == 10'h3FF) begin
            if (ovf_mode) begin
                m_ovf++;
            end else begin
                m_ok++;
                e.op = op; e.src = src; e.d1 = d1; e.d2 = d2; e.d3 = d3; e.cyc = cyc + 1;
                q.push_back(e);
            end
        end
        beat(b2, 1'b1);
    endtask

    task automatic send_rand_good(input logic [9:0] dst, input logic flip, input int gap);
        send_frame(5'($urandom()), dst, 10'($urandom()), $urandom(), $urandom(), $urandom(), flip, gap);
    endtask

    function automatic logic [9:0] rand_dst();
        logic [9:0] d;
        case ($urandom_range(0, 2))
            0: d = local_id;
            1: d = 10'h3FF;
            default: begin
                d = 10'($urandom());
                while (d == local_id || d == 10'h3FF) d = 10'($urandom());
            end
        endcase
        return d;
    endfunction

    logic prev_v = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_v <= 1'b0;
        end else begin
            if (cmd_valid) begin
                if (q.size() == 0) begin
                    chk("unexpected_cmd", 1, 0);
                end else begin
                    if (!prev_v) chk("cmd_latency", cyc, q[0].cyc);
                    chk("cmd_fields", {cmd_op, cmd_src, dt1, dt2, dt3},
                        {q[0].op, q[0].src, q[0].d1, q[0].d2, q[0].d3});
                    if (ready) void'(q.pop_front());
                end
            end
            prev_v <= cmd_valid;
        end
    end

    initial begin
        #1;
        chk("reset_cmd_valid", cmd_valid, 0);
        chk("reset_fields", {cmd_op, cmd_src, dt1, dt2, dt3}, 0);
        check_counters("reset");
        idle(2);
        rst = 1'b0;
        chan_up = 1'b1;
        idle(2);

        send_frame(5'h03, 10'h012, 10'h001, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 0);
        idle(2);
        check_counters("basic");

        send_frame(5'h03, 10'h012, 10'h001, 32'h11111111, 32'h22222222, 32'h33333333, 1'b1, 0);
        idle(2);
        check_counters("badchk");
        send_frame(5'h03, 10'h055, 10'h001, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 0);
        idle(2);
        check_counters("foreign");
        send_frame(5'h03, 10'h3FF, 10'h001, 32'h11111111, 32'h22222222, 32'h33333333, 1'b0, 0);
        idle(2);
        check_counters("bcast");

        beat(rnd64(), 1'b0);
        beat(rnd64(), 1'b1);
        m_len++;
        idle(1);
        check_counters("short");
        for (int i = 0; i < 4; i++) beat(rnd64(), 1'b0);
        beat(rnd64(), 1'b1);
        m_len++;
        send_rand_good(local_id, 1'b0, 0);
        idle(2);
        check_counters("long");

        ready = 1'b0;
        send_rand_good(local_id, 1'b0, 0);
        ovf_mode = 1'b1;
        send_rand_good(10'h3FF, 1'b0, 0);
        ovf_mode = 1'b0;
        idle(3);
        check_counters("ovf");
        ready = 1'b1;
        idle(1);
        chk("ovf_release_valid", cmd_valid, 0);
        idle(2);

        beat(rnd64(), 1'b0);
        beat(rnd64(), 1'b0);
        chan_up = 1'b0;
        beat(rnd64(), 1'b1);
        beat(rnd64(), 1'b0);
        chan_up = 1'b1;
        idle(1);
        send_rand_good(local_id, 1'b0, 1);
        idle(2);
        check_counters("chan_drop");

        for (int i = 0; i < 17; i++) send_rand_good(local_id, 1'b1, 0);
        idle(1);
        check_counters("sat");
        chk("sat_err_chk4_is_F", chk4, 4'hF);

        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 6))
                0, 1: send_rand_good(rand_dst(), 1'b0, 2);
                2: send_rand_good(rand_dst(), 1'b1, 2);
                3: begin
                    beat(rnd64(), 1'b0);
                    idle($urandom_range(0, 2));
                    beat(rnd64(), 1'b1);
                    m_len++;
                end
                4: begin
                    beat(rnd64(), 1'b1);
                    m_len++;
                end
                5: begin
                    for (int j = 0; j < 4; j++) beat(rnd64(), 1'b0);
                    beat(rnd64(), 1'b1);
                    m_len++;
                end
                default: begin
                    beat(rnd64(), 1'b0);
                    beat(rnd64(), 1'b0);
                    chan_up = 1'b0;
                    beat(rnd64(), $urandom_range(0, 1) == 1);
                    chan_up = 1'b1;
                    idle(1);
                    send_rand_good(rand_dst(), 1'b0, 0);
                end
            endcase
            idle($urandom_range(0, 1));
            check_counters("rand");
        end
        idle(3);

        beat(rnd64(), 1'b0);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_mid_valid", cmd_valid, 0);
        chk("rst_mid_fields", {cmd_op, cmd_src, dt1, dt2, dt3}, 0);
        m_ok = 0; m_len = 0; m_chk = 0; m_ovf = 0;
        check_counters("rst_mid");
        idle(1);
        rst = 1'b0;
        idle(1);
        send_rand_good(local_id, 1'b0, 0);
        idle(3);
        check_counters("post_rst");
        chk("queue_drained", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tnet_rx_decoder.md
TNET_RX_DECODER -- requirements
Module: tnet_rx_decoder

Interface
REQ-001 Parameter CNT_W, default 16, width of each saturating statistics counter.
REQ-002 Parameter BCAST_ID, default 10'h3FF, destination ID accepted by every node.
REQ-003 user_clk_i  in  1  sole clock, Aurora RX user clock.
REQ-004 user_rst_i  in  1  asynchronous, active-high reset.
REQ-005 channel_up_i  in  1  Aurora RX channel up.
REQ-006 s_axi_rx_tvalid_i  in  1  RX beat valid; no tready, every valid beat is consumed.
REQ-007 s_axi_rx_tdata_i  in  64  RX beat data.
REQ-008 s_axi_rx_tlast_i  in  1  last beat of frame.
REQ-009 local_id_i  in  10  this node's ID, quasi-static.
REQ-010 cmd_valid_o  out  1  decoded command available.
REQ-011 cmd_ready_i  in  1  consumer accepts command.
REQ-012 cmd_op_o  out  5, cmd_src_o  out  10, cmd_dt1_o / cmd_dt2_o / cmd_dt3_o  out  32 each: decoded fields.
REQ-013 frm_ok_cnt_o, err_len_cnt_o, err_chk_cnt_o, err_ovf_cnt_o  out  CNT_W each: statistics.

Function
REQ-014 Frame: exactly 3 beats, tlast only on beat 2.
REQ-015 Beat 0: [63:59] op, [58:49] dst, [48:39] src, [38:0] ignored; beat 1: [63:32] dt1, [31:0] dt2; beat 2: [63:32] dt3, [31:0] chk.
REQ-016 chk SHALL equal XOR of beat0[63:32], beat0[31:0], beat1[63:32], beat1[31:0], beat2[63:32].
REQ-017 FSM states IDLE, B1, B2, DROP; reset state IDLE.
REQ-018 IDLE: valid beat with tlast=0 -> store beat0, start running XOR, go B1; valid beat with tlast=1 -> err_len++, stay IDLE.
REQ-019 B1: valid beat tlast=0 -> store, go B2; tlast=1 -> err_len++, go IDLE.
REQ-020 B2: valid beat tlast=1 -> evaluate frame, go IDLE; tlast=0 -> err_len++, go DROP.
REQ-021 DROP: discard beats; valid beat with tlast=1 -> IDLE; no counter change.
REQ-022 Cycles with tvalid=0 hold state; no timeout.
REQ-023 channel_up_i=0 in any state -> IDLE next cycle, partial frame discarded silently; beats ignored while channel_up_i=0.
REQ-024 Evaluation: chk mismatch -> err_chk++, drop; else dst not local_id_i and not BCAST_ID -> drop silently, no counter; else deliver.
REQ-025 Delivery: if output register empty, or cmd_valid_o=1 and cmd_ready_i=1 in the same cycle, load fields, cmd_valid_o=1 the cycle after the tlast beat (latency 1), frm_ok++; otherwise err_ovf++, new frame dropped, held command unchanged.
REQ-026 cmd_valid_o clears the cycle after cmd_valid_o & cmd_ready_i unless reloaded per REQ-025; outputs stable while valid and not ready.
REQ-027 Back-to-back frames with no idle beat SHALL decode without loss when cmd_ready_i=1.
REQ-028 Counters saturate at all-ones; a frame increments at most one counter.
REQ-029 Counters and cmd fields SHALL not change on channel_up_i loss; held command persists.

Reset
REQ-030 user_rst_i asserted: FSM IDLE, cmd_valid_o=0, cmd fields 0, all counters 0, running XOR 0, asynchronously.
REQ-031 Reset mid-frame discards the frame; first post-reset beat is treated as beat 0.

Verification
REQ-032 Valid frame op=5'h03, dst=local_id 10'h012, src=10'h001, dt1=32'h11111111, dt2=32'h22222222, dt3=32'h33333333, correct chk, ready=1 -> cmd_valid_o one cycle after beat 2 with those fields, frm_ok=1.
REQ-033 Same frame with chk bit 0 flipped -> no cmd_valid_o, err_chk=1; dst=10'h055 (not local, not broadcast) -> no output, no counter change; dst=10'h3FF -> delivered.
REQ-034 tlast on beat 1 -> err_len=1, IDLE; 5-beat frame -> err_len=1, beats 3-4 discarded, next valid frame delivered.
REQ-035 cmd_ready_i=0, two valid frames back-to-back -> first held stable, err_ovf=1; then ready=1 -> first accepted, cmd_valid_o=0 next cycle.
REQ-036 channel_up_i dropped after beat 1, restored, full frame sent -> only the new frame delivered, no error counted; user_rst_i pulse mid-frame -> all outputs 0 immediately.
REQ-037 Force err_chk to all-ones via 2^CNT_W bad frames (CNT_W=4 build) -> counter holds 4'hF.
